// File: rtl/bin_to_ascii_tx_pkg.sv
// Shared definitions for the binary-to-ASCII UART transmit formatter:
// character codes, FSM state encoding and the message-length helper.
package bin_to_ascii_tx_pkg;

   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;
   localparam logic [7:0] ASCII_STAR = 8'h2A;
   localparam logic [7:0] ASCII_HASH = 8'h23;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Characters per message: one per nibble plus the optional CR/LF pair.
   function automatic logic [3:0] char_count(input int nibbles, input bit crlf);
      return 4'(nibbles + (crlf ? 2 : 0));
   endfunction

endpackage

// File: rtl/bin_to_ascii_tx_nibble_to_ascii.sv
// Combinational keypad-style nibble encoder: 0-9, A-D, '*' (14), '#' (15).
// Inverse of the receive-side ASCII-to-binary decoder.
module nibble_to_ascii
   import bin_to_ascii_tx_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves o_ascii
      // unassigned, which would infer a latch.
      o_ascii = ASCII_HASH;
      if (i_nibble <= 4'd9) begin
         o_ascii = ASCII_0 + {4'd0, i_nibble};
      end else if (i_nibble <= 4'd13) begin
         o_ascii = ASCII_A + {4'd0, i_nibble - 4'd10};
      end else if (i_nibble == 4'd14) begin
         o_ascii = ASCII_STAR;
      end
   end

endmodule

// File: rtl/bin_to_ascii_tx.sv
// Streams a captured binary word as ASCII characters into a UART TX,
// one byte per tx_start/tx_done handshake, with an optional CR/LF tail.
module bin_to_ascii_tx
   import bin_to_ascii_tx_pkg::*;
#(
   parameter int NIBBLES   = 4,
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] value,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_done,
   output logic                 busy,
   output logic                 done
);

   localparam logic [3:0] LAST_IDX = char_count(NIBBLES, SEND_CRLF) - 4'd1;
   localparam logic [3:0] CR_IDX   = 4'(NIBBLES);

   state_t               r_state, w_state_nxt;
   logic [4*NIBBLES-1:0] r_word, w_word_nxt;
   logic [3:0]           r_idx, w_idx_nxt;
   logic [7:0]           r_tx_data, w_tx_data_nxt;
   logic                 r_tx_start, w_tx_start_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_done, w_done_nxt;
   logic [7:0]           w_nib_ascii;
   logic [7:0]           w_char;

   // The word shifts left after each digit, so the current digit is always on top.
   nibble_to_ascii u_nibble_to_ascii (
      .i_nibble (r_word[4*NIBBLES-1 -: 4]),
      .o_ascii  (w_nib_ascii)
   );

   always_comb begin
      w_char = w_nib_ascii;
      if (r_idx == CR_IDX) begin
         w_char = ASCII_CR;
      end else if (r_idx > CR_IDX) begin
         w_char = ASCII_LF;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_word_nxt     = r_word;
      w_idx_nxt      = r_idx;
      w_tx_data_nxt  = r_tx_data;
      w_tx_start_nxt = 1'b0;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_word_nxt  = value;
               w_idx_nxt   = 4'd0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_tx_data_nxt  = w_char;
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               if (r_idx == LAST_IDX) begin
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = FINISH;
               end else begin
                  w_idx_nxt   = r_idx + 4'd1;
                  w_word_nxt  = r_word << 4;
                  w_state_nxt = LOAD;
               end
            end
         end
         FINISH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_word     <= '0;
         r_idx      <= 4'd0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_word     <= w_word_nxt;
         r_idx      <= w_idx_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: doc/bin_to_ascii_tx.md
Name: bin_to_ascii_tx

Overview:
Formats a captured binary word as keypad-style ASCII characters and streams them one byte at a time into the UART transmitter. Each character goes out only after the transmitter signals completion of the previous byte. An optional CR/LF terminator follows the last character. The block sits between the application/keypad logic and the UART TX, mirroring the receive-side ASCII-to-binary decoding.

Parameters:
NIBBLES, 4, number of 4-bit digits in value; MS nibble is sent first; legal range 1..8
SEND_CRLF, 1, 1 = append 0x0D then 0x0A after the digits; 0 = digits only

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to send value; sampled only while idle
value  in  4*NIBBLES  binary word to format; captured on accepted start
tx_data  out  8  ASCII byte to UART TX; held stable from tx_start until matching tx_done
tx_start  out  1  one-cycle pulse, byte on tx_data is valid to transmit
tx_done  in  1  one-cycle pulse from UART TX, byte fully shifted out
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, whole message sent

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state IDLE; tx_data=0x00, tx_start=0, busy=0, done=0; internal word and counters cleared.
  - Reset mid-message abandons the message; no tx_start is re-issued after release.
- Nibble-to-ASCII mapping:
  - 0..9 -> 0x30..0x39.
  - 10..13 -> 'A'..'D' (0x41..0x44).
  - 14 -> '*' (0x2A).
  - 15 -> '#' (0x23).
- States: IDLE, LOAD, WAIT, FINISH. All outputs are registered.
- IDLE:
  - On start=1, capture value and set char index = 0; next state LOAD, busy=1 next cycle.
  - start=0 stays IDLE.
- LOAD:
  - Drive tx_data = ASCII of the current character; pulse tx_start for exactly this one cycle.
  - Next state WAIT.
  - Character order: nibble[NIBBLES-1] .. nibble[0], then CR, LF if SEND_CRLF=1.
- WAIT:
  - tx_data holds its value. On tx_done=1:
    - If more characters remain, increment the index and go to LOAD.
    - If the last character is done, go to FINISH.
  - tx_done is ignored in every state other than WAIT, including the LOAD cycle itself.
- FINISH:
  - done=1 for one cycle, busy=0 in the same cycle; next state IDLE.
- Latency and timing:
  - start accepted at cycle N -> first tx_start at cycle N+2.
  - tx_done at cycle M -> next tx_start at cycle M+2.
  - Final tx_done at cycle M -> done at cycle M+1.
- Total characters per message = NIBBLES + 2*SEND_CRLF. Use a 4-bit index, which covers a maximum of 10.
- start asserted while not IDLE (including the FINISH cycle) is ignored, not queued.
- value changing after capture has no effect on the message in flight.
- tx_start is never asserted twice without an intervening tx_done.

Decomposition:
- Shared package:
  - ASCII constants: ASCII_0=0x30, ASCII_A=0x41, ASCII_STAR=0x2A, ASCII_HASH=0x23, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - State encoding localparams: IDLE, LOAD, WAIT, FINISH.
- One natural sub-module: nibble_to_ascii, a combinational 4-bit to 8-bit mapping (the exact inverse of the receive-side decoder). It is instantiated once on the currently selected nibble; CR/LF selection is muxed in the parent.

Test Plan:
- Basic message: NIBBLES=4, SEND_CRLF=1, value=0x12AF, start pulse; TX model answers tx_done 10 cycles after each tx_start.
  - Required: tx_data sequence 0x31,0x32,0x41,0x23,0x0D,0x0A, exactly 6 tx_start pulses, then one done pulse.
- Symbol coverage: value=0xE0CD.
  - Required: bytes 0x2A,0x30,0x43,0x44,0x0D,0x0A.
  - Also sweep all 16 nibble values through nibble_to_ascii against the mapping table.
- Start while busy: start with value=0x1111, then start again mid-message with value=0x2222.
  - Required: only 0x31 x4 + CR/LF sent, no second message, busy stays 1 until done.
- Asynchronous reset mid-message: assert rst_n=0 while in WAIT after the second byte.
  - Required: outputs 0 immediately; no further tx_start after release until a new start.
  - Then start with value=0x0009: bytes 0x30,0x30,0x30,0x39,0x0D,0x0A.
- Parameter variant and timing: NIBBLES=2, SEND_CRLF=0, value=0x9B; tx_done returned in the cycle right after tx_start.
  - Required: bytes 0x39,0x42; tx_start spacing of 3 cycles; done exactly 1 cycle after the second tx_done.
- Stray tx_done: pulse tx_done while IDLE and in the LOAD cycle.
  - Required: ignored; byte count and order unchanged.
